fpu_issue_ctl: RTL and testbench
================================

Name: fpu_issue_ctl

Overview:
Parametrised decode/issue and integer-writeback controller for the bfloat16 FPU coprocessor. It buffers incoming 32-bit instructions in a FIFO and classifies the head (LUI, ADDI, CSR, FP op, custom reset, illegal). It issues the head only when a 32-entry GPR scoreboard shows no hazard. It then arbitrates the single GPR write port among CSR-read, FPU and integer-ALU results, and overlaps integer ops with an in-flight FP op.

Parameters:
XLEN, 32, integer data / instruction width
IQ_DEPTH, 4, instruction FIFO entries (power of 2, >=2)
NREGS, 32, GPR count tracked by scoreboard (x0 never tracked)

Ports:
clk  in  1  clock
rst_l  in  1  synchronous active-low reset
in_valid  in  1  instruction offered
in_instr  in  XLEN  instruction word
in_ready  out  1  FIFO not full
flush  in  1  discard all FIFO entries (in-flight ops unaffected)
iss_valid  out  1  one-cycle issue pulse
iss_instr  out  XLEN  issued instruction
iss_class  out  3  0 LUI, 1 ADDI, 2 CSR, 3 FP, 4 RESET, 7 illegal
iss_rs1_en  out  1  rs1 read enable for issued op
iss_rs2_en  out  1  rs2 read enable for issued op
fpu_busy  out  1  FP op in flight
fpu_complete  in  1  FP op done (single-cycle pulse)
fpu_result_rd  in  XLEN  FP result bound for GPR
alu_result  in  XLEN  integer result, valid exactly 1 cycle after LUI/ADDI issue
csr_rdata  in  XLEN  CSR read data, valid in issue cycle
illegal  out  1  one-cycle pulse when illegal head is dropped
wb_en  out  1  GPR write enable
wb_addr  out  5  GPR write address
wb_data  out  XLEN  GPR write data

Behaviour:
- Reset: in_ready=0 during reset, then 1. All other outputs are 0. FIFO empty, scoreboard clear, FSM IDLE, hold register empty.
- FIFO: push when in_valid&in_ready. Pop on issue or illegal-drop. Push and pop in the same cycle at full is not allowed (in_ready=0 when full). flush empties the FIFO at the clock edge; a push in the same cycle is dropped.
- Opcode decode [6:0]:
  - 0110111 LUI
  - 0010011 ADDI
  - 1110011 CSR
  - 0010000 RESET
  - {1010011, 1000011, 1000111, 1001011, 1001111} FP
  - anything else illegal: popped after 1 cycle, illegal pulses, nothing issued.
- GPR destination rules:
  - LUI, ADDI: rd!=0.
  - CSR: rd!=0.
  - FP: only when funct7[6:2] is in {11100, 11000, 10100} and rd!=0.
  - RESET: no GPR write.
- Hazard: a source (rs1 for ADDI/CSR-reg/FP; rs2 for FP) or the rd is set in the scoreboard. On a hazard the head waits.
- FSM states: IDLE, FP_WAIT, CSR_WB.
  - IDLE: any legal class may issue.
  - IDLE->FP_WAIT: on FP issue. fpu_busy=1 in FP_WAIT.
  - FP_WAIT: LUI/ADDI may still issue if there is no hazard and the hold register is empty. FP, CSR and RESET wait.
  - FP_WAIT->IDLE: on fpu_complete.
  - IDLE->CSR_WB: on CSR issue with rd!=0. csr_rdata is registered and written next cycle. CSR_WB->IDLE unconditionally.
- Scoreboard: the bit is set at the issue edge and cleared on the wb_en edge for that address. The FP rd is held in an internal register until completion.
- Writeback priority: CSR_WB > fpu_complete > hold register > fresh ALU result.
  - A fresh ALU result that loses arbitration moves to the hold register (1 entry).
  - wb_en is asserted only when rd!=0.
  - fpu_complete with a non-GPR destination does not use the port.
- A RESET issue clears the scoreboard bits only if no op is in flight; otherwise it waits.
- Reset mid-operation: everything returns to reset values. Pending writebacks are lost.
- Latency: an empty FIFO, push at cycle t, gives iss_valid at t+1. An ADDI issued at t is written at t+1 if uncontested.

Optional Feature:
FPU_ISSUE_PERF_EN:
- Defined: adds outputs perf_issued (32b) and perf_stall (32b).
  - perf_issued increments on each iss_valid.
  - perf_stall increments each cycle the FIFO head is valid but not issued/dropped.
  - Both counters wrap at 2^32 and are cleared by reset.
- Undefined: the ports and logic are absent; behaviour is otherwise identical.

Test Plan:
1. Push ADDI x5,x0,7; alu_result=7 -> iss_valid at t+1 class 1, wb_en at t+2 addr 5 data 7, scoreboard bit 5 cleared.
2. Push ADDI x3 then ADDI x4,x3,1 -> second issue waits until the x3 writeback cycle clears, issuing 1 cycle after that wb.
3. FP fmv.x (funct7=1110000) rd=6, then LUI x7; fpu_complete coincides with the LUI result -> wb x6 first, x7 from hold next cycle. fpu_busy is 1 until completion.
4. CSR with rd=9, csr_rdata=0x1F -> FSM goes to CSR_WB, wb_en next cycle addr 9 data 0x0000001F.
5. Fill IQ_DEPTH=4 entries during an FP stall -> in_ready=0. flush -> FIFO empty and in_ready=1, in-flight FP still writes back.
6. Opcode 0000000 pushed -> illegal pulse, no iss_valid, next head issues the following cycle. Drop rst_l mid FP_WAIT -> all outputs 0 next cycle.

Source files
------------

// File: rtl/fpu_issue_ctl.sv
// Decode/issue and integer-writeback controller for the bfloat16 FPU coprocessor.
// Define FPU_ISSUE_PERF_EN to add the perf_issued / perf_stall counters.

module fpu_issue_ctl #(
    parameter int unsigned XLEN     = 32,
    parameter int unsigned IQ_DEPTH = 4,
    parameter int unsigned NREGS    = 32
) (
    input  logic            clk,
    input  logic            rst_l,
    input  logic            in_valid,
    input  logic [XLEN-1:0] in_instr,
    output logic            in_ready,
    input  logic            flush,
    output logic            iss_valid,
    output logic [XLEN-1:0] iss_instr,
    output logic [2:0]      iss_class,
    output logic            iss_rs1_en,
    output logic            iss_rs2_en,
    output logic            fpu_busy,
    input  logic            fpu_complete,
    input  logic [XLEN-1:0] fpu_result_rd,
    input  logic [XLEN-1:0] alu_result,
    input  logic [XLEN-1:0] csr_rdata,
    output logic            illegal,
    output logic            wb_en,
    output logic [4:0]      wb_addr,
`ifdef FPU_ISSUE_PERF_EN
    output logic [31:0]     perf_issued,
    output logic [31:0]     perf_stall,
`endif
    output logic [XLEN-1:0] wb_data
);

    localparam int unsigned AW = (IQ_DEPTH > 1) ? $clog2(IQ_DEPTH) : 1;
    localparam int unsigned CW = AW + 1;
    localparam logic [AW:0] FullCnt = CW'(IQ_DEPTH);

    localparam logic [2:0] ClsLui  = 3'd0;
    localparam logic [2:0] ClsAddi = 3'd1;
    localparam logic [2:0] ClsCsr  = 3'd2;
    localparam logic [2:0] ClsFp   = 3'd3;
    localparam logic [2:0] ClsRst  = 3'd4;
    localparam logic [2:0] ClsIll  = 3'd7;

    typedef enum logic [1:0] {StIdle, StFpWait, StCsrWb} state_e;

    state_e          state_q, state_d;
    logic [XLEN-1:0] mem_q [IQ_DEPTH];
    logic [AW-1:0]   rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
    logic [AW:0]     cnt_q, cnt_d;
    logic [31:0]     sb_q, sb_d;
    logic            alu_v_q, alu_v_d;
    logic [4:0]      alu_rd_q, alu_rd_d;
    logic            hold_v_q, hold_v_d;
    logic [4:0]      hold_rd_q, hold_rd_d;
    logic [XLEN-1:0] hold_data_q, hold_data_d;
    logic [4:0]      fp_rd_q, fp_rd_d;
    logic            fp_wr_q, fp_wr_d;
    logic [4:0]      csr_rd_q, csr_rd_d;
    logic [XLEN-1:0] csr_data_q, csr_data_d;

    logic [XLEN-1:0] head;
    logic [4:0]      rd, rs1, rs2;
    logic [2:0]      cls;
    logic            use_rs1, use_rs2, wr_gpr, rd_tracked, hazard;
    logic            head_v, issue, drop, push, pop, fp_done, hold_win, fresh_win;

    assign head       = mem_q[rd_ptr_q];
    assign rd         = head[11:7];
    assign rs1        = head[19:15];
    assign rs2        = head[24:20];
    assign rd_tracked = (rd != 5'd0) && (32'(rd) < NREGS);
    assign head_v     = rst_l && !flush && (cnt_q != '0);
    assign in_ready   = rst_l && (cnt_q != FullCnt);
    assign push       = in_valid && in_ready;
    assign pop        = issue || drop;
    assign fp_done    = (state_q == StFpWait) && fpu_complete;
    assign fpu_busy   = rst_l && (state_q == StFpWait);

    always_comb begin
        cls     = ClsIll;
        use_rs1 = 1'b0;
        use_rs2 = 1'b0;
        wr_gpr  = 1'b0;
        case (head[6:0])
            7'b0110111: begin cls = ClsLui;  wr_gpr = (rd != 5'd0); end
            7'b0010011: begin cls = ClsAddi; wr_gpr = (rd != 5'd0); use_rs1 = 1'b1; end
            // funct3[2] set selects the immediate (zimm) CSR forms
            7'b1110011: begin cls = ClsCsr;  wr_gpr = (rd != 5'd0); use_rs1 = !head[14]; end
            7'b0010000: cls = ClsRst;
            7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                cls     = ClsFp;
                use_rs1 = 1'b1;
                use_rs2 = 1'b1;
                wr_gpr  = (rd != 5'd0) && ((head[31:27] == 5'b11100) ||
                          (head[31:27] == 5'b11000) || (head[31:27] == 5'b10100));
            end
            default: cls = ClsIll;
        endcase
    end

    assign hazard = (use_rs1 && sb_q[rs1]) || (use_rs2 && sb_q[rs2]) || (wr_gpr && sb_q[rd]);

    always_comb begin
        issue = 1'b0;
        drop  = 1'b0;
        if (head_v) begin
            case (cls)
                ClsLui, ClsAddi: issue = !hazard && ((state_q == StIdle) ||
                                         ((state_q == StFpWait) && !hold_v_q));
                ClsCsr, ClsFp:   issue = !hazard && (state_q == StIdle);
                ClsRst:          issue = (state_q == StIdle) && !alu_v_q && !hold_v_q;
                default:         drop  = 1'b1;
            endcase
        end
    end

    assign iss_valid  = issue;
    assign iss_instr  = issue ? head : '0;
    assign iss_class  = (issue || drop) ? cls : 3'd0;
    assign iss_rs1_en = issue && use_rs1;
    assign iss_rs2_en = issue && use_rs2;
    assign illegal    = drop;

    always_comb begin
        wb_en     = 1'b0;
        wb_addr   = '0;
        wb_data   = '0;
        hold_win  = 1'b0;
        fresh_win = 1'b0;
        if (rst_l) begin
            if (state_q == StCsrWb) begin
                wb_en = 1'b1; wb_addr = csr_rd_q; wb_data = csr_data_q;
            end else if (fp_done && fp_wr_q) begin
                wb_en = 1'b1; wb_addr = fp_rd_q; wb_data = fpu_result_rd;
            end else if (hold_v_q) begin
                wb_en = 1'b1; wb_addr = hold_rd_q; wb_data = hold_data_q; hold_win = 1'b1;
            end else if (alu_v_q) begin
                wb_en = 1'b1; wb_addr = alu_rd_q; wb_data = alu_result; fresh_win = 1'b1;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        rd_ptr_d    = rd_ptr_q;
        wr_ptr_d    = wr_ptr_q;
        cnt_d       = cnt_q;
        sb_d        = sb_q;
        alu_v_d     = issue && ((cls == ClsLui) || (cls == ClsAddi)) && wr_gpr;
        alu_rd_d    = rd;
        hold_v_d    = hold_v_q && !hold_win;
        hold_rd_d   = hold_rd_q;
        hold_data_d = hold_data_q;
        fp_rd_d     = fp_rd_q;
        fp_wr_d     = fp_wr_q;
        csr_rd_d    = csr_rd_q;
        csr_data_d  = csr_data_q;

        unique case (state_q)
            StIdle: begin
                if (issue && (cls == ClsFp)) state_d = StFpWait;
                else if (issue && (cls == ClsCsr) && wr_gpr) state_d = StCsrWb;
            end
            StFpWait: if (fpu_complete) state_d = StIdle;
            StCsrWb:  state_d = StIdle;
            default:  state_d = StIdle;
        endcase

        if (flush) begin
            rd_ptr_d = '0;
            wr_ptr_d = '0;
            cnt_d    = '0;
        end else begin
            if (push) wr_ptr_d = wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end

        // A fresh result that lost the port parks in the hold slot, which is draining then.
        if (alu_v_q && !fresh_win) begin
            hold_v_d    = 1'b1;
            hold_rd_d   = alu_rd_q;
            hold_data_d = alu_result;
        end

        if (wb_en) sb_d[wb_addr] = 1'b0;
        if (issue && wr_gpr && rd_tracked) sb_d[rd] = 1'b1;
        if (issue && (cls == ClsRst)) sb_d = '0;

        if (issue && (cls == ClsFp)) begin
            fp_rd_d = rd;
            fp_wr_d = wr_gpr;
        end
        if (issue && (cls == ClsCsr)) begin
            csr_rd_d   = rd;
            csr_data_d = csr_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (push && !flush) mem_q[wr_ptr_q] <= in_instr;
    end

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            state_q     <= StIdle;
            rd_ptr_q    <= '0;
            wr_ptr_q    <= '0;
            cnt_q       <= '0;
            sb_q        <= '0;
            alu_v_q     <= 1'b0;
            alu_rd_q    <= '0;
            hold_v_q    <= 1'b0;
            hold_rd_q   <= '0;
            hold_data_q <= '0;
            fp_rd_q     <= '0;
            fp_wr_q     <= 1'b0;
            csr_rd_q    <= '0;
            csr_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            rd_ptr_q    <= rd_ptr_d;
            wr_ptr_q    <= wr_ptr_d;
            cnt_q       <= cnt_d;
            sb_q        <= sb_d;
            alu_v_q     <= alu_v_d;
            alu_rd_q    <= alu_rd_d;
            hold_v_q    <= hold_v_d;
            hold_rd_q   <= hold_rd_d;
            hold_data_q <= hold_data_d;
            fp_rd_q     <= fp_rd_d;
            fp_wr_q     <= fp_wr_d;
            csr_rd_q    <= csr_rd_d;
            csr_data_q  <= csr_data_d;
        end
    end

`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_issued_q, perf_stall_q;

    always_ff @(posedge clk) begin
        if (!rst_l) begin
            perf_issued_q <= '0;
            perf_stall_q  <= '0;
        end else begin
            if (issue) perf_issued_q <= perf_issued_q + 32'd1;
            if (head_v && !issue && !drop) perf_stall_q <= perf_stall_q + 32'd1;
        end
    end

    assign perf_issued = perf_issued_q;
    assign perf_stall  = perf_stall_q;
`endif

endmodule

// File: tb/tb_fpu_issue_ctl.sv
// Randomized bench for fpu_issue_ctl against a queue-based behavioural model of the
// issue/writeback rules, preceded by short directed sequences.

module tb_fpu_issue_ctl;

    logic        clk = 1'b0;
    logic        rst_l = 1'b0;
    logic        in_valid = 1'b0;
    logic [31:0] in_instr = '0;
    logic        in_ready;
    logic        flush = 1'b0;
    logic        iss_valid;
    logic [31:0] iss_instr;
    logic [2:0]  iss_class;
    logic        iss_rs1_en, iss_rs2_en, fpu_busy;
    logic        fpu_complete = 1'b0;
    logic [31:0] fpu_result_rd = '0;
    logic [31:0] alu_result = '0;
    logic [31:0] csr_rdata = '0;
    logic        illegal, wb_en;
    logic [4:0]  wb_addr;
    logic [31:0] wb_data;
`ifdef FPU_ISSUE_PERF_EN
    logic [31:0] perf_issued, perf_stall;
`endif

    always #5 clk = ~clk;

    fpu_issue_ctl #(.XLEN(32), .IQ_DEPTH(4), .NREGS(32)) dut (
        .clk           (clk),
        .rst_l         (rst_l),
        .in_valid      (in_valid),
        .in_instr      (in_instr),
        .in_ready      (in_ready),
        .flush         (flush),
        .iss_valid     (iss_valid),
        .iss_instr     (iss_instr),
        .iss_class     (iss_class),
        .iss_rs1_en    (iss_rs1_en),
        .iss_rs2_en    (iss_rs2_en),
        .fpu_busy      (fpu_busy),
        .fpu_complete  (fpu_complete),
        .fpu_result_rd (fpu_result_rd),
        .alu_result    (alu_result),
        .csr_rdata     (csr_rdata),
        .illegal       (illegal),
        .wb_en         (wb_en),
        .wb_addr       (wb_addr),
`ifdef FPU_ISSUE_PERF_EN
        .perf_issued   (perf_issued),
        .perf_stall    (perf_stall),
`endif
        .wb_data       (wb_data)
    );

    int unsigned n_checks = 0;
    int unsigned n_pass = 0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    endtask

    // Model state: FIFO as a queue, pending work as plain flags.
    logic [31:0] m_q[$];
    bit          m_fp_busy, m_fp_wr, m_csr_pend, m_fresh_v, m_hold_v;
    logic [4:0]  m_fp_rd, m_csr_rd, m_fresh_rd, m_hold_rd;
    logic [31:0] m_csr_val, m_hold_val;
    bit          m_sb[32];
    int unsigned m_issued;

    task automatic m_reset();
        m_q.delete();
        m_fp_busy = 0; m_fp_wr = 0; m_csr_pend = 0; m_fresh_v = 0; m_hold_v = 0;
        foreach (m_sb[i]) m_sb[i] = 0;
        m_issued = 0;
    endtask

    function automatic void decode(input logic [31:0] ins, output int cls, output bit wr,
                                   output bit r1, output bit r2);
        logic [4:0] rdf;
        rdf = ins[11:7];
        wr = 0; r1 = 0; r2 = 0;
        case (ins[6:0])
            7'b0110111: begin cls = 0; wr = (rdf != 0); end
            7'b0010011: begin cls = 1; wr = (rdf != 0); r1 = 1; end
            7'b1110011: begin cls = 2; wr = (rdf != 0); r1 = !ins[14]; end
            7'b0010000: cls = 4;
            7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111: begin
                cls = 3; r1 = 1; r2 = 1;
                wr = (rdf != 0) && (ins[31:27] inside {5'b11100, 5'b11000, 5'b10100});
            end
            default: cls = 7;
        endcase
    endfunction

    function automatic logic [31:0] mk(input int cls, input logic [4:0] rd, input logic [4:0] rs1,
                                       input logic [4:0] rs2);
        logic [6:0]  fp_ops [5];
        logic [6:0]  f7s [5];
        logic [31:0] r;
        logic [2:0]  f3;
        fp_ops = '{7'b1010011, 7'b1000011, 7'b1000111, 7'b1001011, 7'b1001111};
        f7s    = '{7'b1110000, 7'b1100000, 7'b1010000, 7'b0000000, 7'b0001100};
        r = $urandom;
        case (cls)
            0: return {r[31:12], rd, 7'b0110111};
            1: return {r[31:20], rs1, 3'b000, rd, 7'b0010011};
            2: begin
                f3 = 3'($urandom_range(1, 7));
                if (f3 == 3'd4) f3 = 3'd1;
                return {r[31:20], rs1, f3, rd, 7'b1110011};
            end
            3: return {f7s[$urandom_range(0, 4)], rs2, rs1, r[14:12], rd,
                       fp_ops[$urandom_range(0, 4)]};
            4: return {r[31:7], 7'b0010000};
            default: return {r[31:7], (r[0] ? 7'b0000000 : 7'b0000011)};
        endcase
    endfunction

    // One clock: drive at negedge, compare 1ns later, then advance the model past the posedge.
    task automatic step(input bit v, input logic [31:0] ins, input bit fl, input bit rst,
                        input bit cmp);
        logic [31:0] head, e_data;
        logic [4:0]  rd, rs1, rs2, e_addr;
        int          cls, src;
        bit          wr, r1, r2, idle, haz, iss, drop, rdy;
        @(negedge clk);
        in_valid = v; in_instr = ins; flush = fl; rst_l = rst;
        fpu_complete  = cmp && rst && m_fp_busy;
        alu_result    = $urandom;
        csr_rdata     = $urandom;
        fpu_result_rd = $urandom;
        #1;
        if (!rst) begin
            check_eq("rst_in_ready", 32'(in_ready), 0);
            check_eq("rst_iss_valid", 32'(iss_valid), 0);
            check_eq("rst_iss_instr", iss_instr, 0);
            check_eq("rst_iss_class", 32'(iss_class), 0);
            check_eq("rst_rs_en", {30'd0, iss_rs1_en, iss_rs2_en}, 0);
            check_eq("rst_illegal", 32'(illegal), 0);
            check_eq("rst_fpu_busy", 32'(fpu_busy), 0);
            check_eq("rst_wb_en", 32'(wb_en), 0);
            check_eq("rst_wb_addr", 32'(wb_addr), 0);
            check_eq("rst_wb_data", wb_data, 0);
            m_reset();
            return;
        end
        rdy  = (m_q.size() < 4);
        idle = !m_fp_busy && !m_csr_pend;
        iss = 0; drop = 0; cls = 0; wr = 0; r1 = 0; r2 = 0; head = '0; rd = '0;
        if (m_q.size() > 0 && !fl) begin
            head = m_q[0];
            rd = head[11:7]; rs1 = head[19:15]; rs2 = head[24:20];
            decode(head, cls, wr, r1, r2);
            haz = (r1 && m_sb[rs1]) || (r2 && m_sb[rs2]) || (wr && m_sb[rd]);
            case (cls)
                0, 1: iss = !haz && (idle || (m_fp_busy && !m_hold_v));
                2, 3: iss = !haz && idle;
                4:    iss = idle && !m_fresh_v && !m_hold_v;
                default: drop = 1;
            endcase
        end
        src = 0; e_addr = '0; e_data = '0;
        if (m_csr_pend) begin src = 1; e_addr = m_csr_rd; e_data = m_csr_val; end
        else if (m_fp_busy && fpu_complete && m_fp_wr) begin
            src = 2; e_addr = m_fp_rd; e_data = fpu_result_rd;
        end else if (m_hold_v) begin src = 3; e_addr = m_hold_rd; e_data = m_hold_val; end
        else if (m_fresh_v) begin src = 4; e_addr = m_fresh_rd; e_data = alu_result; end

        check_eq("in_ready", 32'(in_ready), 32'(rdy));
        check_eq("iss_valid", 32'(iss_valid), 32'(iss));
        check_eq("iss_instr", iss_instr, iss ? head : 32'd0);
        check_eq("iss_class", 32'(iss_class), (iss || drop) ? 32'(cls) : 32'd0);
        check_eq("iss_rs1_en", 32'(iss_rs1_en), 32'(iss && r1));
        check_eq("iss_rs2_en", 32'(iss_rs2_en), 32'(iss && r2));
        check_eq("illegal", 32'(illegal), 32'(drop));
        check_eq("fpu_busy", 32'(fpu_busy), 32'(m_fp_busy));
        check_eq("wb_en", 32'(wb_en), 32'(src != 0));
        check_eq("wb_addr", 32'(wb_addr), 32'(e_addr));
        check_eq("wb_data", wb_data, e_data);

        if (src != 0) m_sb[e_addr] = 0;
        if (m_fresh_v && src != 4) begin
            m_hold_v = 1; m_hold_rd = m_fresh_rd; m_hold_val = alu_result;
        end else if (src == 3) m_hold_v = 0;
        m_csr_pend = 0;
        m_fresh_v = 0;
        if (m_fp_busy && fpu_complete) m_fp_busy = 0;
        if (iss) begin
            m_issued++;
            if (wr) m_sb[rd] = 1;
            case (cls)
                0, 1: if (wr) begin m_fresh_v = 1; m_fresh_rd = rd; end
                2: if (wr) begin m_csr_pend = 1; m_csr_rd = rd; m_csr_val = csr_rdata; end
                3: begin m_fp_busy = 1; m_fp_rd = rd; m_fp_wr = wr; end
                default: foreach (m_sb[i]) m_sb[i] = 0;
            endcase
        end
        if (iss || drop) void'(m_q.pop_front());
        if (fl) m_q.delete();
        else if (v && rdy) m_q.push_back(ins);
    endtask

    task automatic idle_n(input int n, input bit cmp);
        for (int i = 0; i < n; i++) step(0, '0, 0, 1, cmp);
    endtask

    logic [31:0] fmvx;
    int          rc;

    initial begin
        m_reset();
        for (int i = 0; i < 3; i++) step(0, '0, 0, 0, 0);

        // ADDI x5,x0,7 then dependent ADDI chain
        step(1, {12'd7, 5'd0, 3'b000, 5'd5, 7'b0010011}, 0, 1, 0);
        idle_n(3, 0);
        step(1, {12'd1, 5'd0, 3'b000, 5'd3, 7'b0010011}, 0, 1, 0);
        step(1, {12'd1, 5'd3, 3'b000, 5'd4, 7'b0010011}, 0, 1, 0);
        idle_n(4, 0);

        // fmv.x x6 then LUI x7; completion collides with the LUI result
        fmvx = {7'b1110000, 5'd0, 5'd1, 3'b000, 5'd6, 7'b1010011};
        step(1, fmvx, 0, 1, 0);
        step(1, {20'h12345, 5'd7, 7'b0110111}, 0, 1, 0);
        step(0, '0, 0, 1, 0);
        step(0, '0, 0, 1, 1);
        idle_n(3, 0);

        // CSR rd=9, register form
        step(1, {12'h300, 5'd0, 3'b001, 5'd9, 7'b1110011}, 0, 1, 0);
        idle_n(3, 0);

        // Fill the FIFO behind a stalled FP op, then flush
        step(1, fmvx, 0, 1, 0);
        for (int i = 0; i < 5; i++) step(1, mk(3, 5'd0, 5'd1, 5'd2), 0, 1, 0);
        step(0, '0, 1, 1, 0);
        idle_n(2, 0);
        step(0, '0, 0, 1, 1);
        idle_n(2, 0);

        // Illegal head followed by a legal one; then reset during FP_WAIT
        step(1, 32'h0000_0000, 0, 1, 0);
        step(1, {20'h1, 5'd2, 7'b0110111}, 0, 1, 0);
        idle_n(3, 0);
        step(1, fmvx, 0, 1, 0);
        idle_n(2, 0);
        step(0, '0, 0, 0, 1);
        idle_n(2, 1);

        for (int i = 0; i < 4000; i++) begin
            rc = $urandom_range(0, 9);
            if (rc == 9) rc = 1;
            if (rc == 8) rc = 7;
            step($urandom_range(0, 9) < 6,
                 mk(rc, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7))),
                 $urandom_range(0, 49) == 0, $urandom_range(0, 299) != 0,
                 $urandom_range(0, 2) == 0);
        end

`ifdef FPU_ISSUE_PERF_EN
        #1;
        check_eq("perf_issued", perf_issued, m_issued);
`endif
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
